uart_tx_ctrl: RTL

//  Sequencer for the UART transmit path: accepts bytes over a valid/ready handshake, gates
//  the tx_baud_rate generator via baud_en and advances one serial bit per baud tick (en).

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and line constants.
package uart_pkg;

    // Transmit sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Level of the serial line when nothing is being sent
    localparam logic TX_IDLE_LEVEL = 1'b1;

    // System clocks per bit period; the external tx_baud_rate generator uses the same value
    localparam int CLKS_PER_BIT = 2604;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: one-entry holding register, start/data/parity/stop
// framing, and gating of the external baud generator. All outputs are registered.
//
// Handshake: tx_data is captured into the holding register on a rising clk edge
// where tx_valid & tx_ready are both high. tx_ready mirrors "holding register
// empty" and is registered; tx_valid while tx_ready is low is ignored and the
// source must keep tx_valid/tx_data stable until the accepting edge.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 baud_en,
    input  logic                 baud_tick,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output tx_state_t            state
);

    localparam int              BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic            PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic            HAS_PAR   = (PARITY_EN != 0) ? 1'b1 : 1'b0;

    logic [DATA_BITS-1:0] hold;
    logic                 hold_valid;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;

    tx_state_t            state_n;
    logic [DATA_BITS-1:0] hold_n;
    logic                 hold_valid_n;
    logic [DATA_BITS-1:0] shift_n;
    logic                 par_n;
    logic [BW-1:0]        bit_cnt_n;
    logic                 stop_cnt_n;
    logic                 tx_done_n;
    logic                 line_lvl;
    logic                 load;
    logic                 accept;

    // tx_ready is exactly !hold_valid, so an accept and a load never coincide
    assign accept = tx_valid & tx_ready;

    // Next-state, holding register, shifter and line level for the current state
    always_comb begin
        state_n      = state;
        hold_n       = hold;
        hold_valid_n = hold_valid;
        shift_n      = shift;
        par_n        = par_bit;
        bit_cnt_n    = bit_cnt;
        stop_cnt_n   = stop_cnt;
        tx_done_n    = 1'b0;
        line_lvl     = TX_IDLE_LEVEL;
        load         = 1'b0;

        if (accept) begin
            hold_n       = tx_data;
            hold_valid_n = 1'b1;
        end

        case (state)
            IDLE: begin
                // Ticks are ignored here; only a held byte starts a frame
                if (hold_valid) begin
                    load = 1'b1;
                end
            end
            START: begin
                line_lvl = 1'b0;
                if (baud_tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                line_lvl = shift[0];
                if (baud_tick) begin
                    shift_n   = shift >> 1;
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_n    = HAS_PAR ? PARITY : STOP;
                        stop_cnt_n = 1'b0;
                    end
                end
            end
            PARITY: begin
                line_lvl = par_bit;
                if (baud_tick) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            STOP: begin
                line_lvl = 1'b1;
                if (baud_tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        tx_done_n = 1'b1;
                        // A waiting byte goes straight into its start bit
                        if (hold_valid) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Parity is taken from the byte as loaded, since the shifter destroys it
        if (load) begin
            shift_n      = hold;
            par_n        = (^hold) ^ PAR_ODD;
            hold_valid_n = 1'b0;
            state_n      = START;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx         <= TX_IDLE_LEVEL;
            baud_en    <= 1'b0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
            shift      <= shift_n;
            par_bit    <= par_n;
            bit_cnt    <= bit_cnt_n;
            stop_cnt   <= stop_cnt_n;
            tx         <= line_lvl;
            baud_en    <= (state_n != IDLE);
            tx_ready   <= !hold_valid_n;
            tx_busy    <= (state_n != IDLE) | hold_valid_n;
            tx_done    <= tx_done_n;
        end
    end

endmodule
